// File: rtl/kgp_pkg.sv
// Shared processor package: register-file geometry and the types built on it.
`timescale 1ns/1ps
package kgp_pkg;
  localparam int NUM_REGS  = 32;
  localparam int DATA_W    = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0]    reg_data_t;
endpackage

// File: rtl/reg_file.sv
// NUM_REGS x DATA_W register file: one write port, two read ports, and a debug mirror of ROUT_IDX.
// Writes land on the rising Clk edge; reads are combinational from stored state (no bypass).
`timescale 1ns/1ps
module reg_file #(
  parameter int NUM_REGS = kgp_pkg::NUM_REGS,
  parameter int DATA_W   = kgp_pkg::DATA_W,
  parameter int ROUT_IDX = 1
) (
  input  logic                          Clk,
  input  logic                          rst,
  input  logic [kgp_pkg::REG_IDX_W-1:0] WriteReg,
  input  logic [DATA_W-1:0]             WriteData,
  input  logic                          RegWrite,
  input  logic [kgp_pkg::REG_IDX_W-1:0] ReadReg1,
  input  logic [kgp_pkg::REG_IDX_W-1:0] ReadReg2,
  output logic [DATA_W-1:0]             ReadData1,
  output logic [DATA_W-1:0]             ReadData2,
  output logic [DATA_W-1:0]             rout
);
  import kgp_pkg::*;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // Register 0 is an ordinary storage location, not a hard-wired zero.
  always_comb begin
    regs_d = regs_q;
    if (RegWrite) regs_d[WriteReg] = WriteData;
  end

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign ReadData1 = regs_q[ReadReg1];
  assign ReadData2 = regs_q[ReadReg2];
  assign rout      = regs_q[ROUT_IDX];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: a reference model feeds a scoreboard queue of expected port values.
`timescale 1ns/1ps
module tb_reg_file;
  logic        Clk;
  logic        rst;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] rout;

  reg_file #(.NUM_REGS(32), .DATA_W(32), .ROUT_IDX(1)) dut (
    .Clk       (Clk),
    .rst       (rst),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .RegWrite  (RegWrite),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2),
    .rout      (rout)
  );

  initial Clk = 1'b0;
  always #1 Clk = ~Clk;

  typedef struct {
    string       tag;
    int          port;   // 0: ReadData1, 1: ReadData2, 2: rout
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [32];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int port, input logic [31:0] exp);
    exp_t e;
    e.tag  = tag;
    e.port = port;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // Expected values for all three outputs at the current read indices, from the model.
  task automatic push_all(input string tag);
    push({tag, "_rd1"}, 0, mdl[ReadReg1]);
    push({tag, "_rd2"}, 1, mdl[ReadReg2]);
    push({tag, "_rout"}, 2, mdl[1]);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      case (e.port)
        0:       obs = ReadData1;
        1:       obs = ReadData2;
        default: obs = rout;
      endcase
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
  endtask

  // Called at a negedge: checks pre-edge reads, crosses one rising edge, checks post-edge reads.
  task automatic do_write(input string tag, input logic [4:0] idx, input logic [31:0] data,
                          input logic we, input logic [4:0] rd1, input logic [4:0] rd2);
    WriteReg  = idx;
    WriteData = data;
    RegWrite  = we;
    ReadReg1  = rd1;
    ReadReg2  = rd2;
    #0.2;
    push_all({tag, "_pre"});
    drain();
    @(posedge Clk);
    if (we && !rst) mdl[idx] = data;
    @(negedge Clk);
    RegWrite = 1'b0;
    #0.2;
    push_all({tag, "_post"});
    drain();
  endtask

  initial begin
    rst       = 1'b1;
    WriteReg  = '0;
    WriteData = '0;
    RegWrite  = 1'b0;
    ReadReg1  = '0;
    ReadReg2  = '0;
    model_reset();

    // Reset held for 100 ns; every index must read zero.
    #100;
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i);
      ReadReg2 = 5'(31 - i);
      #0.1;
      push("rst_rd1", 0, 32'h0);
      push("rst_rd2", 1, 32'h0);
      push("rst_rout", 2, 32'h0);
      drain();
    end

    @(negedge Clk);
    rst = 1'b0;
    #0.2;
    push_all("rst_release");
    drain();

    // Write r0 = 4: r0 is writable, rout (r1) unaffected.
    do_write("wr_r0", 5'd0, 32'd4, 1'b1, 5'd0, 5'd1);
    check("wr_r0_const_rd1", ReadData1, 32'd4);
    check("wr_r0_const_rout", rout, 32'd0);

    // Write r1 = 5 with ReadReg1=1: old value before the edge, new after; rout follows.
    do_write("wr_r1", 5'd1, 32'd5, 1'b1, 5'd1, 5'd0);
    check("wr_r1_const_rd1", ReadData1, 32'd5);
    check("wr_r1_const_rout", rout, 32'd5);

    // Write disabled across several edges.
    for (int k = 0; k < 3; k++) begin
      do_write("wr_dis", 5'd1, 32'd9, 1'b0, 5'd0, 5'd1);
      check("wr_dis_const_rd1", ReadData1, 32'd4);
      check("wr_dis_const_rd2", ReadData2, 32'd5);
    end

    // Both read ports on the register being written.
    do_write("same_reg", 5'd2, 32'hDEAD_BEEF, 1'b1, 5'd2, 5'd2);

    // Sweep: distinct value into every register.
    for (int i = 0; i < 32; i++)
      do_write("sweep_wr", 5'(i), 32'hA5A5_0000 + 32'(i), 1'b1, 5'(i), 5'((i + 1) % 32));

    // Rewriting the same value is harmless.
    do_write("rewrite", 5'd5, 32'hA5A5_0005, 1'b1, 5'd5, 5'd6);
    do_write("rewrite", 5'd5, 32'hA5A5_0005, 1'b1, 5'd4, 5'd5);

    // All read-index pairs.
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        ReadReg1 = 5'(a);
        ReadReg2 = 5'(b);
        #0.1;
        push_all("pairs");
        drain();
      end
    end
    check("sweep_rout_const", rout, 32'hA5A5_0001);

    // Asynchronous reset between edges: outputs clear before the next rising edge.
    @(negedge Clk);
    ReadReg1 = 5'd7;
    ReadReg2 = 5'd1;
    #0.3;
    rst = 1'b1;
    model_reset();
    #0.2;
    push_all("arst");
    drain();

    // Writes during reset are ignored.
    do_write("wr_in_rst", 5'd3, 32'h1234_5678, 1'b1, 5'd3, 5'd0);

    @(negedge Clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i);
      ReadReg2 = 5'(i ^ 5'h1F);
      #0.05;
      push_all("post_arst");
      drain();
    end
    @(negedge Clk);
    do_write("post_arst_wr", 5'd31, 32'h0BAD_F00D, 1'b1, 5'd31, 5'd30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
